// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock mode/edit sequencer: display modes,
// key-pulse bit positions and edit-field selection.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DISP      = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  typedef enum logic {
    FIELD_MIN  = 1'b0,
    FIELD_HOUR = 1'b1
  } field_e;

  localparam int unsigned KEY_MODE  = 0;
  localparam int unsigned KEY_FIELD = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_DOWN  = 3;

  // Mode-key successor; SET_ALARM is skipped when the alarm is not built.
  function automatic mode_e next_mode(input mode_e m, input logic alarm_en);
    mode_e n;
    case (m)
      MODE_DISP:      n = MODE_SET_TIME;
      MODE_SET_TIME:  n = alarm_en ? MODE_SET_ALARM : MODE_STOPWATCH;
      MODE_SET_ALARM: n = MODE_STOPWATCH;
      default:        n = MODE_DISP;
    endcase
    return n;
  endfunction

  function automatic logic is_set_mode(input mode_e m);
    return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_tick_down_cnt.sv
// Loadable down counter that decrements once per tick and saturates at 0.
module tick_down_cnt
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over the tick decrement; stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/edit sequencer for the digital clock: key pulses and the 1 Hz tick
// become a registered mode, edit field, command pulses, stopwatch control,
// blink mask and alarm beep. The alarm (SET_ALARM mode, al_* pulses, beep)
// is built only when CLOCK_ALARM_EN is defined.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned BEEP_SECS    = 10,
  parameter int unsigned IDLE_TIMEOUT = 30
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [3:0] key_pls,
  input  logic       tick_1hz,
  input  logic       alarm_hit,
  output logic [1:0] mode,
  output logic       field,
  output logic       tm_inc,
  output logic       tm_dec,
  output logic       al_inc,
  output logic       al_dec,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       blink,
  output logic       beep
);

  mode_e      r_mode,   w_mode_nxt;
  field_e     r_field,  w_field_nxt;
  logic       r_tm_inc, w_tm_inc_nxt;
  logic       r_tm_dec, w_tm_dec_nxt;
  logic       r_al_inc, w_al_inc_nxt;
  logic       r_al_dec, w_al_dec_nxt;
  logic       r_sw_run, w_sw_run_nxt;
  logic       r_sw_clr, w_sw_clr_nxt;
  logic       r_blink,  w_blink_nxt;
  logic [5:0] r_idle,   w_idle_nxt;
  logic [5:0] w_idle_inc;
  logic       w_consume;
  logic       w_key_act;
  logic       w_up;
  logic       w_dn;

`ifdef CLOCK_ALARM_EN
  localparam logic ALARM_EN = 1'b1;

  logic       r_hit_q;
  logic       r_beep;
  logic       w_beep_nxt;
  logic       w_rise;
  logic       w_load;
  logic       w_expire;
  logic       w_beep_zero;
  logic [3:0] w_beep_cnt;

  tick_down_cnt #(.W(4)) u_beep_cnt (
    .i_clk      (mclk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (4'(BEEP_SECS)),
    .i_tick     (tick_1hz),
    .o_cnt      (w_beep_cnt),
    .o_zero     (w_beep_zero)
  );

  assign w_rise    = alarm_hit & ~r_hit_q;
  assign w_load    = w_rise & ~r_beep;
  assign w_expire  = tick_1hz & ~w_beep_zero & (w_beep_cnt == 4'd1);
  assign w_consume = r_beep & (|key_pls);

  // Beep: start on a fresh alarm edge, stop on a key or when the count runs out.
  always_comb begin
    w_beep_nxt = r_beep;
    if (w_load) begin
      w_beep_nxt = 1'b1;
    end else if (w_consume || (r_beep && w_expire)) begin
      w_beep_nxt = 1'b0;
    end
  end

  // Alarm edge history and beep flag.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_hit_q <= 1'b0;
      r_beep  <= 1'b0;
    end else begin
      r_hit_q <= alarm_hit;
      r_beep  <= w_beep_nxt;
    end
  end

  assign beep = r_beep;
`else
  localparam logic ALARM_EN = 1'b0;

  logic w_unused_alarm;
  assign w_unused_alarm = alarm_hit | (BEEP_SECS == 0);
  assign w_consume      = 1'b0;
  assign beep           = 1'b0;
`endif

  assign w_key_act  = (|key_pls) & ~w_consume;
  assign w_up       = w_key_act & key_pls[KEY_UP] & ~key_pls[KEY_DOWN];
  assign w_dn       = w_key_act & key_pls[KEY_DOWN] & ~key_pls[KEY_UP];
  assign w_idle_inc = r_idle + 6'd1;

  // Next state: mode key first, then field/up/down per mode, then tick effects.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_field_nxt  = r_field;
    w_tm_inc_nxt = 1'b0;
    w_tm_dec_nxt = 1'b0;
    w_al_inc_nxt = 1'b0;
    w_al_dec_nxt = 1'b0;
    w_sw_run_nxt = r_sw_run;
    w_sw_clr_nxt = 1'b0;
    w_blink_nxt  = r_blink;
    w_idle_nxt   = r_idle;

    if (w_key_act && key_pls[KEY_MODE]) begin
      w_mode_nxt  = next_mode(r_mode, ALARM_EN);
      w_field_nxt = FIELD_MIN;
      w_blink_nxt = 1'b0;
      w_idle_nxt  = '0;
    end else if (is_set_mode(r_mode)) begin
      if (tick_1hz) begin
        w_blink_nxt = ~r_blink;
      end
      if (w_key_act) begin
        w_idle_nxt = '0;
      end else if (tick_1hz) begin
        if ((IDLE_TIMEOUT != 0) && (w_idle_inc == 6'(IDLE_TIMEOUT))) begin
          w_mode_nxt  = MODE_DISP;
          w_field_nxt = FIELD_MIN;
          w_blink_nxt = 1'b0;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end
      if (w_key_act && key_pls[KEY_FIELD]) begin
        w_field_nxt = field_e'(~r_field);
      end
      if (w_up || w_dn) begin
        w_blink_nxt = 1'b0;
      end
      if (r_mode == MODE_SET_TIME) begin
        w_tm_inc_nxt = w_up;
        w_tm_dec_nxt = w_dn;
      end else begin
        w_al_inc_nxt = ALARM_EN & w_up;
        w_al_dec_nxt = ALARM_EN & w_dn;
      end
    end else begin
      w_blink_nxt = 1'b0;
      w_idle_nxt  = '0;
      if (r_mode == MODE_STOPWATCH) begin
        if (w_up) begin
          w_sw_run_nxt = ~r_sw_run;
        end
        if (w_dn) begin
          w_sw_clr_nxt = 1'b1;
          w_sw_run_nxt = 1'b0;
        end
      end
    end
  end

  // State register for mode, field, commands, stopwatch, blink and idle count.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_mode   <= MODE_DISP;
      r_field  <= FIELD_MIN;
      r_tm_inc <= 1'b0;
      r_tm_dec <= 1'b0;
      r_al_inc <= 1'b0;
      r_al_dec <= 1'b0;
      r_sw_run <= 1'b0;
      r_sw_clr <= 1'b0;
      r_blink  <= 1'b0;
      r_idle   <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_field  <= w_field_nxt;
      r_tm_inc <= w_tm_inc_nxt;
      r_tm_dec <= w_tm_dec_nxt;
      r_al_inc <= w_al_inc_nxt;
      r_al_dec <= w_al_dec_nxt;
      r_sw_run <= w_sw_run_nxt;
      r_sw_clr <= w_sw_clr_nxt;
      r_blink  <= w_blink_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  assign mode   = r_mode;
  assign field  = r_field;
  assign tm_inc = r_tm_inc;
  assign tm_dec = r_tm_dec;
  assign al_inc = r_al_inc;
  assign al_dec = r_al_dec;
  assign sw_run = r_sw_run;
  assign sw_clr = r_sw_clr;
  assign blink  = r_blink;

endmodule
